rewire_step_sched: RTL and testbench

Round-robin scheduler that shares one ReWire-generated step device (a `top_level` with 8-bit `__in0`/`__out0`, one resumption step per enabled cycle) among up to NREQ requesters. It grants at most one requester per cycle and drives the device input with a step strobe. It routes each device output back to the requester that issued the step. It supports exclusive multi-step sessions through a lock, and a flush that drains and resets the device's resumption state. It sits between the requester fabric and the device wrapper, which gates the device's state update with `dev_step`.

---
 rtl/rewire_step_sched.sv | 140 ++++++++++++++
 tb/tb_rewire_step_sched.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rewire_step_sched.sv
// Round-robin/lockable scheduler in front of one ReWire step device; grant and dev_in are combinational,
// responses return LAT+1 cycles after the grant; no grant while flushing, resetting or locked by another requester; responses cannot stall.
module rewire_step_sched #(
    parameter int NREQ    = 4,
    parameter int W       = 8,
    parameter int LAT     = 0,
    parameter int RST_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_data,
    input  logic [NREQ-1:0]   req_lock,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   resp_valid,
    output logic [W-1:0]      resp_data,
    input  logic              flush,
    output logic              busy,
    output logic [W-1:0]      dev_in,
    output logic              dev_step,
    output logic              dev_rst,
    input  logic [W-1:0]      dev_out
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(RST_CYC + 1);

    typedef enum logic [1:0] {S_RESET, S_IDLE, S_LOCKED, S_DRAIN} state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   ptr, owner;
    logic [CW-1:0]   rst_cnt;
    logic [W-1:0]    dev_in_q;
    logic            gnt_vld;
    logic [IW-1:0]   gnt_id;
    logic            smp_vld;
    logic [IW-1:0]   smp_id;
    logic            inflight, inflight_nxt;
    logic            busy_nxt;

    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] a, input int b);
        int s;
        s = int'(a) + b;
        if (s >= NREQ) s = s - NREQ;
        return IW'(s);
    endfunction

    // Flush wins over any grant in the same cycle.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        if (!rst && !flush) begin
            if (state == S_IDLE) begin
                for (int k = NREQ - 1; k >= 0; k--) begin
                    if (req_valid[wrap_add(ptr, k)]) begin
                        gnt_vld = 1'b1;
                        gnt_id  = wrap_add(ptr, k);
                    end
                end
            end else if (state == S_LOCKED && req_valid[owner]) begin
                gnt_vld = 1'b1;
                gnt_id  = owner;
            end
        end
    end

    assign req_ready = gnt_vld ? (NREQ'(1) << gnt_id) : '0;
    assign dev_step  = gnt_vld;
    assign dev_in    = gnt_vld ? req_data[gnt_id*W +: W] : dev_in_q;
    assign dev_rst   = rst | (state == S_RESET);

    generate
        if (LAT == 0) begin : g_lat0
            assign smp_vld      = gnt_vld;
            assign smp_id       = gnt_id;
            assign inflight     = 1'b0;
            assign inflight_nxt = 1'b0;
        end else begin : g_pipe
            logic [LAT-1:0]         pipe_vld;
            logic [LAT-1:0][IW-1:0] pipe_id;

            always_ff @(posedge clk) begin
                if (rst) begin
                    pipe_vld <= '0;
                    pipe_id  <= '0;
                end else begin
                    pipe_vld[0] <= gnt_vld;
                    pipe_id[0]  <= gnt_id;
                    for (int k = 1; k < LAT; k++) begin
                        pipe_vld[k] <= pipe_vld[k-1];
                        pipe_id[k]  <= pipe_id[k-1];
                    end
                end
            end

            assign smp_vld      = pipe_vld[LAT-1];
            assign smp_id       = pipe_id[LAT-1];
            assign inflight     = |pipe_vld;
            // The last stage leaves this cycle; everything else shifts along.
            assign inflight_nxt = gnt_vld | (|(pipe_vld & ~(LAT'(1) << (LAT - 1))));
        end
    endgenerate

    always_comb begin
        state_nxt = state;
        case (state)
            S_RESET:  if (rst_cnt == CW'(RST_CYC - 1)) state_nxt = S_IDLE;
            S_IDLE, S_LOCKED: begin
                if (flush)        state_nxt = S_DRAIN;
                else if (gnt_vld) state_nxt = req_lock[gnt_id] ? S_LOCKED : S_IDLE;
            end
            S_DRAIN:  if (!inflight) state_nxt = S_RESET;
            default:  state_nxt = S_RESET;
        endcase
        busy_nxt = (state_nxt == S_RESET) || (state_nxt == S_DRAIN) || inflight_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_RESET;
            rst_cnt    <= '0;
            ptr        <= '0;
            owner      <= '0;
            dev_in_q   <= '0;
            resp_valid <= '0;
            resp_data  <= '0;
            busy       <= 1'b1;
        end else begin
            state   <= state_nxt;
            rst_cnt <= (state == S_RESET) ? rst_cnt + CW'(1) : '0;
            if (gnt_vld) begin
                ptr      <= wrap_add(gnt_id, 1);
                owner    <= gnt_id;
                dev_in_q <= dev_in;
            end
            resp_valid <= smp_vld ? (NREQ'(1) << smp_id) : '0;
            if (smp_vld) resp_data <= dev_out;
            busy <= busy_nxt;
        end
    end
endmodule

// File: tb/tb_rewire_step_sched.sv
// Bench for rewire_step_sched: LAT=0 and LAT=2 instances share stimulus, each behind an accumulator device.
module tb_rewire_step_sched;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int RC = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    rv = '0, rl = '0;
    logic [N*W-1:0]  rd = '0;
    logic            fl = 1'b0;

    logic [N-1:0]    rr [2];
    logic [N-1:0]    rsv [2];
    logic [W-1:0]    rsd [2], din [2], dout [2];
    logic            bsy [2], dst [2], drs [2];

    always #5 clk = ~clk;

    rewire_step_sched #(.NREQ(N), .W(W), .LAT(0), .RST_CYC(RC)) u0 (
        .clk(clk), .rst(rst), .req_valid(rv), .req_data(rd), .req_lock(rl),
        .req_ready(rr[0]), .resp_valid(rsv[0]), .resp_data(rsd[0]), .flush(fl),
        .busy(bsy[0]), .dev_in(din[0]), .dev_step(dst[0]), .dev_rst(drs[0]), .dev_out(dout[0]));

    rewire_step_sched #(.NREQ(N), .W(W), .LAT(2), .RST_CYC(RC)) u2 (
        .clk(clk), .rst(rst), .req_valid(rv), .req_data(rd), .req_lock(rl),
        .req_ready(rr[1]), .resp_valid(rsv[1]), .resp_data(rsd[1]), .flush(fl),
        .busy(bsy[1]), .dev_in(din[1]), .dev_step(dst[1]), .dev_rst(drs[1]), .dev_out(dout[1]));

    // Device: running sum of stepped inputs, output is the post-step sum (LAT 0 or 2).
    logic [W-1:0] acc [2];
    logic [W-1:0] d1, d2;
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (drs[i])      acc[i] <= '0;
            else if (dst[i]) acc[i] <= acc[i] + din[i];
        end
        d1 <= acc[1] + din[1];
        d2 <= d1;
    end
    assign dout[0] = acc[0] + din[0];
    assign dout[1] = d2;

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference model: mode 0=RESET 1=IDLE 2=LOCKED 3=DRAIN; responses stored by due cycle.
    int           cyc = 0;
    int           m_mode [2] = '{0, 0};
    int           m_rcnt [2] = '{0, 0};
    int           m_ptr  [2] = '{0, 0};
    int           m_own  [2] = '{0, 0};
    logic [W-1:0] m_sum  [2] = '{8'h0, 8'h0};
    logic [W-1:0] m_din  [2] = '{8'h0, 8'h0};
    bit           ev   [2][1024];
    int           eid  [2][1024];
    logic [W-1:0] edat [2][1024];

    function automatic int lat_of(input int i);
        return (i == 0) ? 0 : 2;
    endfunction

    function automatic int exp_gnt(input int i);
        if (rst || fl) return -1;
        if (m_mode[i] == 1) begin
            for (int k = 0; k < N; k++) begin
                if (rv[(m_ptr[i] + k) % N]) return (m_ptr[i] + k) % N;
            end
        end
        if (m_mode[i] == 2 && rv[m_own[i]]) return m_own[i];
        return -1;
    endfunction

    function automatic bit in_flight(input int i);
        for (int c = cyc + 1; c <= cyc + lat_of(i); c++)
            if (ev[i][c % 1024]) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk) begin : model_upd
        int g;
        for (int i = 0; i < 2; i++) begin
            g = exp_gnt(i);
            ev[i][cyc % 1024] = 1'b0;
            if (rst) begin
                m_mode[i] = 0; m_rcnt[i] = 0; m_ptr[i] = 0; m_own[i] = 0;
                m_sum[i] = '0; m_din[i] = '0;
                for (int c = cyc + 1; c <= cyc + 8; c++) ev[i][c % 1024] = 1'b0;
            end else begin
                case (m_mode[i])
                    0: begin
                        m_sum[i] = '0;
                        if (m_rcnt[i] == RC - 1) begin m_mode[i] = 1; m_rcnt[i] = 0; end
                        else m_rcnt[i]++;
                    end
                    1, 2: begin
                        if (fl) m_mode[i] = 3;
                        else if (g >= 0) begin
                            m_sum[i] = m_sum[i] + rd[g*W +: W];
                            m_din[i] = rd[g*W +: W];
                            ev[i][(cyc + lat_of(i) + 1) % 1024]   = 1'b1;
                            eid[i][(cyc + lat_of(i) + 1) % 1024]  = g;
                            edat[i][(cyc + lat_of(i) + 1) % 1024] = m_sum[i];
                            m_ptr[i] = (g + 1) % N;
                            if (rl[g]) begin m_mode[i] = 2; m_own[i] = g; end
                            else m_mode[i] = 1;
                        end
                    end
                    default: if (!in_flight(i)) begin m_mode[i] = 0; m_rcnt[i] = 0; end
                endcase
            end
        end
        cyc++;
    end

    always @(negedge clk) begin : compare
        int g;
        if (cyc > 0) begin
            for (int i = 0; i < 2; i++) begin
                g = exp_gnt(i);
                check($sformatf("u%0d req_ready c%0d", i, cyc), rr[i], (g >= 0) ? (1 << g) : 0);
                check($sformatf("u%0d dev_step c%0d", i, cyc), dst[i], (g >= 0) ? 1 : 0);
                check($sformatf("u%0d dev_in c%0d", i, cyc), din[i],
                      (g >= 0) ? int'(rd[g*W +: W]) : int'(m_din[i]));
                check($sformatf("u%0d dev_rst c%0d", i, cyc), drs[i], (rst || m_mode[i] == 0) ? 1 : 0);
                check($sformatf("u%0d resp_valid c%0d", i, cyc), rsv[i],
                      ev[i][cyc % 1024] ? (1 << eid[i][cyc % 1024]) : 0);
                if (ev[i][cyc % 1024])
                    check($sformatf("u%0d resp_data c%0d", i, cyc), rsd[i], edat[i][cyc % 1024]);
                check($sformatf("u%0d busy c%0d", i, cyc), bsy[i],
                      (m_mode[i] == 0 || m_mode[i] == 3 || in_flight(i)) ? 1 : 0);
            end
        end
    end

    int rr_exp   [8] = '{1, 2, 3, 0, 1, 2, 3, 0};
    int lock_exp [4] = '{1, 1, 1, 2};
    // {req_valid, req_lock, flush}
    logic [8:0] tab [12] = '{9'b1111_0000_0, 9'b0110_0100_0, 9'b0111_0100_0, 9'b0011_0000_0,
                             9'b1001_1001_0, 9'b1001_1001_1, 9'b0000_0000_0, 9'b0000_0000_0,
                             9'b0000_0000_0, 9'b0000_0000_0, 9'b1100_0000_0, 9'b1010_0010_0};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int idx(input logic [N-1:0] oh);
        for (int k = 0; k < N; k++) if (oh == (N'(1) << k)) return k;
        return -1;
    endfunction

    initial begin : stim
        int nresp, ndrs;
        rst = 1'b1;
        tick(); tick();
        @(negedge clk);
        check("rst req_ready", rr[0], 0);
        check("rst busy", bsy[1], 1);
        check("rst dev_rst", drs[0], 1);
        check("rst resp_valid", rsv[1], 0);
        check("rst resp_data", rsd[0], 0);
        check("rst dev_in", din[1], 0);
        tick(); rst = 1'b0;
        @(negedge clk);
        check("post-rst dev_rst", drs[0], 1);
        check("post-rst dev_step", dst[0], 0);
        tick(); tick();

        // single step on requester 0
        rv = 4'b0001; rd = 32'h0000_0005;
        @(negedge clk);
        check("step0 dev_step", dst[0], 1);
        check("step0 dev_in", din[0], 8'h05);
        tick(); rv = '0;
        @(negedge clk);
        check("step0 resp_valid", rsv[0], 4'b0001);
        check("step0 resp_data", rsd[0], 8'h05);
        tick(); tick(); tick();

        // round robin with everyone valid
        for (int k = 0; k < 8; k++) begin
            rv = 4'b1111; rl = '0;
            rd = {8'(k + 'h30), 8'(k + 'h20), 8'(k + 'h10), 8'(k)};
            @(negedge clk);
            check($sformatf("rr grant %0d", k), idx(rr[0]), rr_exp[k]);
            tick();
        end

        // lock session on requester 1
        for (int k = 0; k < 4; k++) begin
            rv = (k < 3) ? 4'b0111 : 4'b0101;
            rl = (k < 2) ? 4'b0010 : 4'b0000;
            rd = {8'(k + 'h70), 8'(k + 'h60), 8'(k + 'h50), 8'(k + 'h40)};
            @(negedge clk);
            check($sformatf("lock grant %0d", k), idx(rr[0]), lock_exp[k]);
            tick();
        end
        rv = '0; rl = '0;
        tick(); tick(); tick();

        // two steps then flush, with a valid request in the flush cycle
        rv = 4'b1000; rd = 32'h0900_0000; tick();
        rv = 4'b0001; rd = 32'h0000_0011; tick();
        fl = 1'b1;
        @(negedge clk);
        check("flush u2 req_ready", rr[1], 0);
        check("flush u2 dev_step", dst[1], 0);
        check("flush u0 req_ready", rr[0], 0);
        tick(); rv = '0; fl = 1'b0;
        nresp = 0; ndrs = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (drs[1]) ndrs++;
            if (|rsv[1]) nresp++;
            tick();
        end
        check("flush resp count", nresp, 2);
        check("flush dev_rst cycles", ndrs, RC);
        @(negedge clk);
        check("flush busy after", bsy[1], 0);
        rv = 4'b0100; rd = 32'h0023_0000;
        @(negedge clk);
        check("post-flush u2 step", dst[1], 1);
        tick(); rv = '0;
        tick(); tick(); tick();

        // reset with two steps in flight
        rv = 4'b0001; rd = 32'h0000_0031; tick();
        rv = 4'b0010; rd = 32'h0000_4200; tick();
        rv = '0; rst = 1'b1; tick();
        rst = 1'b0;
        nresp = 0;
        @(negedge clk);
        check("midrst u2 resp_valid", rsv[1], 0);
        check("midrst u2 resp_data", rsd[1], 0);
        check("midrst u2 dev_in", din[1], 0);
        check("midrst u2 dev_rst", drs[1], 1);
        check("midrst u2 busy", bsy[1], 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (|rsv[1]) nresp++;
            tick();
        end
        check("midrst resp count", nresp, 0);

        // mixed traffic: drops, locks, flush inside a lock
        for (int k = 0; k < 12; k++) begin
            rv = tab[k][8:5]; rl = tab[k][4:1]; fl = tab[k][0];
            rd = {8'(3 * k + 1), 8'(5 * k + 2), 8'(7 * k + 3), 8'(11 * k + 4)};
            tick();
        end
        rv = '0; rl = '0; fl = 1'b0;
        for (int k = 0; k < 6; k++) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
